mmio_uart_tx: RTL

- Memory-mapped UART transmitter on the processor's data-memory bus; consumes the core's load/store stream downstream of the processor top.
- Stores to TXDATA push bytes into a small FIFO.
- A baud-timed FSM serialises FIFO bytes onto `tx` as 8N1 frames.
- Loads from STATUS return FIFO and transmitter state combinationally, for single-cycle load timing.

---
 rtl/uart_mmio_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/mmio_uart_tx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - shared FSM states, register offsets and STATUS bit map for mmio_uart_tx
package uart_mmio_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Register offsets from BASE_ADDR
   localparam logic [31:0] TXDATA_OFS = 32'h0;
   localparam logic [31:0] STATUS_OFS = 32'h4;

   // STATUS register bit positions
   localparam int STAT_EMPTY     = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_BUSY      = 2;
   localparam int STAT_OVERFLOW  = 3;
   localparam int STAT_COUNT_LSB = 4;
   localparam int STAT_PARITY    = 12;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with occupancy count
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   push, din      write strobe and data; ignored while full
//   pop, dout      read strobe and head data (dout valid while !empty); ignored while empty
//   full, empty    derived from the registered count
//   count          entries held, $clog2(DEPTH)+1 bits
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= din;
            wptr      <= wptr + AW'(1);
         end
         if (do_pop) begin
            rptr <= rptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with TX FIFO (optional parity: UART_PARITY_EN)
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   mem_write         store strobe, one cycle per store
//   mem_read          load strobe
//   addr, wdata       byte address and store data (wdata[7:0] used for TXDATA)
//   rdata             combinational load data, 0 unless a STATUS read hits
//   hit               combinational, addr falls in {BASE, BASE+4}
//   tx                serial line, idle high
//
// Registers: TXDATA at BASE+0 (write pushes a byte), STATUS at BASE+4
// (read: empty, full, busy, overflow, count, parity-present; write clears overflow).
// Defining UART_PARITY_EN inserts an even-parity bit between data and stop.
module mmio_uart_tx
   import uart_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_write,
   input  logic        mem_read,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        hit,
   output logic        tx
);

   localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_PARITY_EN
   localparam uart_state_t AFTER_DATA     = ST_PARITY;
   localparam logic        PARITY_PRESENT = 1'b1;
`else
   localparam uart_state_t AFTER_DATA     = ST_STOP;
   localparam logic        PARITY_PRESENT = 1'b0;
`endif

   // Decode
   logic txdata_wr;
   logic status_wr;
   logic status_rd;

   assign hit       = (addr[31:3] == BASE_ADDR[31:3]);
   assign txdata_wr = mem_write && (addr == BASE_ADDR + TXDATA_OFS);
   assign status_wr = mem_write && (addr == BASE_ADDR + STATUS_OFS);
   assign status_rd = mem_read && hit && addr[2];

   logic unused_wdata;
   assign unused_wdata = ^wdata[31:8];

   // TX FIFO
   logic            fifo_pop;
   logic [7:0]      fifo_dout;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CNTW-1:0] fifo_count;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (txdata_wr),
      .pop   (fifo_pop),
      .din   (wdata[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Sticky overflow. fifo_full is the registered flag, so a store that meets
   // a full FIFO is dropped even if the FSM pops on the same edge; a set on
   // the same edge as a clearing STATUS write takes priority.
   logic overflow;

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (txdata_wr && fifo_full) begin
         overflow <= 1'b1;
      end else if (status_wr) begin
         overflow <= 1'b0;
      end
   end

   // Transmit FSM
   uart_state_t   state, state_n;
   logic [BW-1:0] baud_cnt, baud_n;
   logic [2:0]    bit_idx, idx_n;
   logic [7:0]    shift, shift_n;
   logic          bit_done;
`ifdef UART_PARITY_EN
   logic          parity_bit, parity_n;
`endif

   assign bit_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
`ifdef UART_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_idx  <= idx_n;
         shift    <= shift_n;
`ifdef UART_PARITY_EN
         parity_bit <= parity_n;
`endif
      end
   end

   always_comb begin
      state_n  = state;
      baud_n   = baud_cnt;
      idx_n    = bit_idx;
      shift_n  = shift;
      fifo_pop = 1'b0;
      tx       = 1'b1;
`ifdef UART_PARITY_EN
      parity_n = parity_bit;
`endif
      if (state != ST_IDLE) begin
         baud_n = bit_done ? '0 : baud_cnt + BW'(1);
      end
      unique case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_n  = fifo_dout;
               baud_n   = '0;
               idx_n    = '0;
               state_n  = ST_START;
`ifdef UART_PARITY_EN
               // Data shifts out of the register, so capture parity at pop time.
               parity_n = ^fifo_dout;
`endif
            end
         end
         ST_START: begin
            tx = 1'b0;
            if (bit_done) begin
               state_n = ST_DATA;
               idx_n   = '0;
            end
         end
         ST_DATA: begin
            tx = shift[0];
            if (bit_done) begin
               shift_n = {1'b0, shift[7:1]};
               idx_n   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_n = AFTER_DATA;
               end
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            tx = parity_bit;
            if (bit_done) begin
               state_n = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            tx = 1'b1;
            if (bit_done) begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // STATUS read mux
   logic [31:0] status;

   always_comb begin
      status                          = '0;
      status[STAT_EMPTY]              = fifo_empty;
      status[STAT_FULL]               = fifo_full;
      status[STAT_BUSY]               = (state != ST_IDLE);
      status[STAT_OVERFLOW]           = overflow;
      status[STAT_COUNT_LSB +: 8]     = 8'(fifo_count);
      status[STAT_PARITY]             = PARITY_PRESENT;
   end

   assign rdata = status_rd ? status : 32'h0;

endmodule
